data_island_scheduler: RTL

// - Sequences HDMI control/video/data-island periods per line from the timing generator's cx/cy.
// - Places one data island per line in horizontal blanking; emits preambles, guard-band marks, packet_enable and packet_pixel_counter for the packet picker.
// - Emits video_field_end for InfoFrame rescheduling. Sits between the timing generator and packet picker/TMDS encoders.

---
 rtl/data_island_pkg.sv | 28 ++
 rtl/video_period_marker.sv | 50 +++++
 rtl/data_island_scheduler.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/data_island_pkg.sv
// Shared types and constants for the HDMI data-island scheduler.
// The optional DATA_ISLAND_NULL_SKIP_EN build macro is consumed by data_island_scheduler.
package data_island_pkg;

  typedef enum logic [2:0] {
    MODE_CONTROL      = 3'd0,
    MODE_VIDEO        = 3'd1,
    MODE_VIDEO_GUARD  = 3'd2,
    MODE_ISLAND       = 3'd3,
    MODE_ISLAND_GUARD = 3'd4
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_PREAMBLE    = 3'd1,
    ST_LEAD_GUARD  = 3'd2,
    ST_PACKET      = 3'd3,
    ST_TRAIL_GUARD = 3'd4
  } island_state_t;

  localparam logic [3:0] CTL_VIDEO_PREAMBLE  = 4'b0001;
  localparam logic [3:0] CTL_ISLAND_PREAMBLE = 4'b0101;

  localparam int PREAMBLE_LEN = 8;
  localparam int GUARD_LEN    = 2;
  localparam int PACKET_LEN   = 32;

endpackage

// File: rtl/video_period_marker.sv
// Decodes cx/cy into the video-related period: active video, the video
// preamble/guard band ahead of an active line, and the field-end point.
// Purely combinational; the scheduler top registers the result.
module video_period_marker
  import data_island_pkg::*;
#(
  parameter int BIT_WIDTH     = 12,
  parameter int BIT_HEIGHT    = 11,
  parameter int FRAME_WIDTH   = 800,
  parameter int FRAME_HEIGHT  = 525,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480
) (
  input  logic [BIT_WIDTH-1:0]  cx_i,
  input  logic [BIT_HEIGHT-1:0] cy_i,
  output mode_t                 vid_mode_o,
  output logic [3:0]            vid_ctl_o,
  output logic                  field_end_o
);

  localparam logic [BIT_WIDTH-1:0]  SW_X      = BIT_WIDTH'(SCREEN_WIDTH);
  localparam logic [BIT_WIDTH-1:0]  PRE_FIRST = BIT_WIDTH'(FRAME_WIDTH - 10);
  localparam logic [BIT_WIDTH-1:0]  PRE_LAST  = BIT_WIDTH'(FRAME_WIDTH - 3);
  localparam logic [BIT_WIDTH-1:0]  GRD_FIRST = BIT_WIDTH'(FRAME_WIDTH - 2);
  localparam logic [BIT_WIDTH-1:0]  LAST_X    = BIT_WIDTH'(FRAME_WIDTH - 1);
  localparam logic [BIT_HEIGHT-1:0] SH_Y      = BIT_HEIGHT'(SCREEN_HEIGHT);
  localparam logic [BIT_HEIGHT-1:0] LAST_Y    = BIT_HEIGHT'(FRAME_HEIGHT - 1);

  logic [BIT_HEIGHT-1:0] next_y;
  logic                  next_active;

  assign next_y      = (cy_i == LAST_Y) ? '0 : cy_i + 1'b1;
  assign next_active = (next_y < SH_Y);

  // Active video wins; otherwise the tail of a line preceding an active line carries preamble then guard.
  always_comb begin
    vid_mode_o = MODE_CONTROL;
    vid_ctl_o  = 4'b0000;
    if (cx_i < SW_X && cy_i < SH_Y) begin
      vid_mode_o = MODE_VIDEO;
    end else if (next_active && cx_i >= GRD_FIRST && cx_i <= LAST_X) begin
      vid_mode_o = MODE_VIDEO_GUARD;
    end else if (next_active && cx_i >= PRE_FIRST && cx_i <= PRE_LAST) begin
      vid_ctl_o = CTL_VIDEO_PREAMBLE;
    end
  end

  assign field_end_o = (cx_i == LAST_X) && (cy_i == LAST_Y);

endmodule

// File: rtl/data_island_scheduler.sv
// Per-line HDMI period sequencer: video/control periods from the marker plus
// one data island per line in horizontal blanking.
// Build macro DATA_ISLAND_NULL_SKIP_EN: end the island early once the packet
// picker reports no pending content (first packet always sent).
module data_island_scheduler
  import data_island_pkg::*;
#(
  parameter int BIT_WIDTH     = 12,
  parameter int BIT_HEIGHT    = 11,
  parameter int FRAME_WIDTH   = 800,
  parameter int FRAME_HEIGHT  = 525,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int ISLAND_OFFSET = 4,
  parameter int MAX_PACKETS   = 18
) (
  input  logic                  clk_pixel,
  input  logic                  reset,
  input  logic [BIT_WIDTH-1:0]  cx,
  input  logic [BIT_HEIGHT-1:0] cy,
  input  logic                  island_enable,
  input  logic                  packet_pending,
  output mode_t                 mode,
  output logic [3:0]            ctl,
  output logic                  packet_enable,
  output logic [4:0]            packet_pixel_counter,
  output logic                  video_field_end
);

  // 26 = island preamble + both island guards + minimum control + video preamble + video guard.
  localparam int RAW_PACKETS = (FRAME_WIDTH - SCREEN_WIDTH - ISLAND_OFFSET - 26) / PACKET_LEN;
  localparam int NUM_PACKETS = (RAW_PACKETS < MAX_PACKETS) ? RAW_PACKETS : MAX_PACKETS;
  localparam int PW          = $clog2(MAX_PACKETS + 1);

  localparam logic [BIT_WIDTH-1:0] ISLAND_START = BIT_WIDTH'(SCREEN_WIDTH + ISLAND_OFFSET);
  localparam logic [4:0]           PRE_LAST     = 5'(PREAMBLE_LEN - 1);
  localparam logic [4:0]           GRD_LAST     = 5'(GUARD_LEN - 1);
  localparam logic [4:0]           GRD_PENULT   = 5'(GUARD_LEN - 2);
  localparam logic [4:0]           PKT_LAST     = 5'(PACKET_LEN - 1);
  localparam logic [4:0]           PKT_PENULT   = 5'(PACKET_LEN - 2);
  localparam logic [PW-1:0]        FINAL_PKT    = PW'(NUM_PACKETS - 1);

  if (NUM_PACKETS < 1) begin : g_no_room
    $error("data_island_scheduler: horizontal blanking too short for one data island");
  end

  mode_t         vid_mode;
  logic [3:0]    vid_ctl;
  logic          vid_field_end;
  island_state_t state_q;
  logic [4:0]    cnt_q;
  logic [PW-1:0] pkt_q;
  logic          more_pkts;

  video_period_marker #(
    .BIT_WIDTH    (BIT_WIDTH),
    .BIT_HEIGHT   (BIT_HEIGHT),
    .FRAME_WIDTH  (FRAME_WIDTH),
    .FRAME_HEIGHT (FRAME_HEIGHT),
    .SCREEN_WIDTH (SCREEN_WIDTH),
    .SCREEN_HEIGHT(SCREEN_HEIGHT)
  ) u_marker (
    .cx_i       (cx),
    .cy_i       (cy),
    .vid_mode_o (vid_mode),
    .vid_ctl_o  (vid_ctl),
    .field_end_o(vid_field_end)
  );

  // Decided at pixel 30 so the strobe lands on pixel 31; the registered strobe then steers the FSM.
`ifdef DATA_ISLAND_NULL_SKIP_EN
  assign more_pkts = (pkt_q != FINAL_PKT) && packet_pending;
`else
  logic unused_pending;
  assign unused_pending = packet_pending;
  assign more_pkts      = (pkt_q != FINAL_PKT);
`endif

  // Island FSM with registered outputs; outputs default to the video marker and island states override.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_q              <= ST_IDLE;
      cnt_q                <= '0;
      pkt_q                <= '0;
      mode                 <= MODE_CONTROL;
      ctl                  <= 4'b0000;
      packet_enable        <= 1'b0;
      packet_pixel_counter <= '0;
      video_field_end      <= 1'b0;
    end else begin
      mode                 <= vid_mode;
      ctl                  <= vid_ctl;
      packet_enable        <= 1'b0;
      packet_pixel_counter <= '0;
      video_field_end      <= vid_field_end;
      if (state_q != ST_IDLE && cx == '0) begin
        // Timing generator restarted the line under us: drop the island.
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        pkt_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (cx == ISLAND_START && island_enable) begin
              state_q <= ST_PREAMBLE;
              cnt_q   <= '0;
              pkt_q   <= '0;
              mode    <= MODE_CONTROL;
              ctl     <= CTL_ISLAND_PREAMBLE;
            end
          end
          ST_PREAMBLE: begin
            if (cnt_q == PRE_LAST) begin
              state_q <= ST_LEAD_GUARD;
              cnt_q   <= '0;
              mode    <= MODE_ISLAND_GUARD;
              ctl     <= 4'b0000;
            end else begin
              cnt_q <= cnt_q + 5'd1;
              mode  <= MODE_CONTROL;
              ctl   <= CTL_ISLAND_PREAMBLE;
            end
          end
          ST_LEAD_GUARD: begin
            if (cnt_q == GRD_LAST) begin
              state_q <= ST_PACKET;
              cnt_q   <= '0;
              mode    <= MODE_ISLAND;
              ctl     <= 4'b0000;
            end else begin
              cnt_q         <= cnt_q + 5'd1;
              mode          <= MODE_ISLAND_GUARD;
              ctl           <= 4'b0000;
              packet_enable <= (cnt_q == GRD_PENULT);
            end
          end
          ST_PACKET: begin
            if (cnt_q == PKT_LAST && packet_enable) begin
              cnt_q <= '0;
              pkt_q <= pkt_q + 1'b1;
              mode  <= MODE_ISLAND;
              ctl   <= 4'b0000;
            end else if (cnt_q == PKT_LAST) begin
              state_q <= ST_TRAIL_GUARD;
              cnt_q   <= '0;
              mode    <= MODE_ISLAND_GUARD;
              ctl     <= 4'b0000;
            end else begin
              cnt_q                <= cnt_q + 5'd1;
              mode                 <= MODE_ISLAND;
              ctl                  <= 4'b0000;
              packet_pixel_counter <= cnt_q + 5'd1;
              packet_enable        <= (cnt_q == PKT_PENULT) && more_pkts;
            end
          end
          ST_TRAIL_GUARD: begin
            if (cnt_q == GRD_LAST) begin
              state_q <= ST_IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 5'd1;
              mode  <= MODE_ISLAND_GUARD;
              ctl   <= 4'b0000;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

endmodule
